// File: rtl/arm32_pkg.sv
// Shared fetch-path constants and types for the ARM32 front end.
package arm32_pkg;

    localparam int ARCH       = 32;
    localparam int INS_BYTES  = 4;
    // Number of low PC bits forced to zero for word alignment.
    localparam int ALIGN_BITS = $clog2(INS_BYTES);

    localparam logic [ARCH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered instruction together with the byte address it came from.
    typedef struct packed {
        logic [ARCH-1:0] pc;
        logic [ARCH-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/arm32_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs between memory and decode.
module arm32_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_pop;

    assign do_pop = pop_i && (cnt_q != '0);

    // Pointer and occupancy tracking; flush discards everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
        end
    end

    // Entry storage; data needs no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/arm32_fetch_unit.sv
// Instruction fetch: PC generation, credit-limited memory requests,
// in-order response capture and redirect with stale-response discard.
module arm32_fetch_unit
    import arm32_pkg::*;
#(
    parameter int              ARCH     = arm32_pkg::ARCH,
    parameter int              DEPTH    = 4,
    parameter logic [ARCH-1:0] RESET_PC = ARCH'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [ARCH-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [ARCH-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [ARCH-1:0] redirect_pc,
    output logic            ins_valid,
    output logic [ARCH-1:0] ins,
    output logic [ARCH-1:0] ins_pc,
    input  logic            ins_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ARCH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ARCH-1:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              run_q;
    logic [CW-1:0]     fifo_count;
    logic [2*ARCH-1:0] fifo_head;
    logic [CW:0]       credit_used;
    logic [ARCH-1:0]   target_pc;
    logic              rsp, accept, push, pop;
    logic              unused_lo_bits;

    // Responses with nothing outstanding are unsolicited and ignored.
    assign rsp         = imem_rvalid && (out_q != '0);
    // Slots already claimed: buffered entries plus live (non-dropped) requests.
    assign credit_used = {1'b0, fifo_count} + {1'b0, out_q} - {1'b0, drop_q};
    assign imem_req    = run_q && !redirect_valid
                         && (credit_used < (CW+1)'(DEPTH))
                         && (out_q < CW'(DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req && imem_ready;

    assign target_pc      = {redirect_pc[ARCH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    assign unused_lo_bits = ^redirect_pc[ALIGN_BITS-1:0];

    assign push      = rsp && (drop_q == '0) && !redirect_valid;
    assign ins_valid = (fifo_count != '0);
    assign pop       = ins_valid && ins_ready && !redirect_valid;
    assign ins_pc    = fifo_head[2*ARCH-1:ARCH];
    assign ins       = fifo_head[ARCH-1:0];

    // Next-state for PCs, outstanding count and drop count; redirect wins.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            out_d      = out_q - CW'(rsp);
            drop_d     = out_q - CW'(rsp);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + ARCH'(INS_BYTES);
            out_d = out_q + CW'(accept) - CW'(rsp);
            if (rsp) begin
                if (drop_q != '0) drop_d    = drop_q - CW'(1);
                else              resp_pc_d = resp_pc_q + ARCH'(INS_BYTES);
            end
        end
    end

    // Control state registers; run_q holds off requests until reset has released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            run_q      <= 1'b1;
        end
    end

    arm32_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*ARCH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({resp_pc_q, imem_rdata}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_arm32_fetch_unit.sv
// Bench for arm32_fetch_unit: memory model with variable latency and a
// stream-level reference (expected fetch address and expected decode PC).
module tb_arm32_fetch_unit;
    import arm32_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] XMASK = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;

    always #5 clk = ~clk;

    arm32_fetch_unit #(.ARCH(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t         pend[$];
    fetch_entry_t pop_log[$];
    int           cyc = 0;
    int           last_due = 0;
    int           lat_lo = 1;
    int           lat_hi = 1;
    int           checks = 0;
    int           failures = 0;
    int           n_acc = 0;
    int           n_pop = 0;
    logic [31:0]  exp_fetch;
    logic [31:0]  exp_pc;
    logic         s_acc, s_valid, s_req, s_rvalid;
    logic [31:0]  s_addr;
    int           s_cyc;

    // One clock cycle: memory answers, outputs sampled mid-cycle, model advances.
    task automatic step();
        int lat, due;
        fetch_entry_t e;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ XMASK;
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_cyc    = cyc;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_valid  = ins_valid;
        s_rvalid = imem_rvalid;
        s_acc    = imem_req && imem_ready;
        if (redirect_valid) begin
            checks++;
            if (imem_req !== 1'b0) begin
                failures++;
                $display("FAIL req_in_redirect got=%b exp=0", imem_req);
            end
        end
        if (s_acc) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
                failures++;
                $display("FAIL fetch_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, exp_fetch);
            end
            lat = $urandom_range(lat_hi, lat_lo);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: imem_addr, due: due});
            checks++;
            if (pend.size() > DEPTH) begin
                failures++;
                $display("FAIL outstanding got=%0d exp<=%0d", pend.size(), DEPTH);
            end
            exp_fetch = exp_fetch + 32'd4;
            n_acc++;
        end
        if (ins_valid && ins_ready && !redirect_valid) begin
            checks++;
            if (ins_pc !== exp_pc || ins !== (exp_pc ^ XMASK)) begin
                failures++;
                $display("FAIL pop cyc=%0d got pc=%h ins=%h exp pc=%h ins=%h",
                         cyc, ins_pc, ins, exp_pc, exp_pc ^ XMASK);
            end
            e.pc  = ins_pc;
            e.ins = ins;
            pop_log.push_back(e);
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (redirect_valid) begin
            exp_fetch = {redirect_pc[31:2], 2'b00};
            exp_pc    = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_ready     = 1'b0;
        ins_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        pend.delete();
        last_due = 0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_fetch = RPC;
        exp_pc    = RPC;
        n_acc     = 0;
        n_pop     = 0;
    endtask

    task automatic test_reset();
        do_reset();
        reset      = 1'b1;
        imem_ready = 1'b1;
        ins_ready  = 1'b1;
        #2;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RPC || ins_valid !== 1'b0
            || ins !== 32'h0 || ins_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b addr=%h v=%b ins=%h pc=%h exp 0/%h/0/0/0",
                     imem_req, imem_addr, ins_valid, ins, ins_pc, RPC);
        end
    endtask

    task automatic test_stream();
        int fa, fv;
        do_reset();
        lat_lo = 1; lat_hi = 1;
        imem_ready = 1'b1; ins_ready = 1'b1;
        fa = -1; fv = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_acc && fa < 0) fa = s_cyc;
            if (s_valid && fv < 0) fv = s_cyc;
        end
        checks++;
        if (fa < 0 || fv - fa != 2) begin
            failures++;
            $display("FAIL stream_latency got=%0d exp=2", fv - fa);
        end
        checks++;
        if (n_pop < 15) begin
            failures++;
            $display("FAIL stream_throughput got=%0d exp>=15", n_pop);
        end
    endtask

    task automatic test_backpressure();
        int base;
        do_reset();
        lat_lo = 1; lat_hi = 1;
        imem_ready = 1'b1; ins_ready = 1'b0;
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (n_acc != DEPTH) begin
            failures++;
            $display("FAIL bp_accepts got=%0d exp=%0d", n_acc, DEPTH);
        end
        checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full got req=%b valid=%b exp req=0 valid=1", s_req, s_valid);
        end
        base = pop_log.size();
        ins_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (pop_log.size() < base + 8 || pop_log[base+3].pc !== 32'hC
            || pop_log[base+4].pc !== 32'h10) begin
            failures++;
            $display("FAIL bp_drain got pops=%0d exp>=8 in order from 0x0", pop_log.size() - base);
        end
    endtask

    task automatic test_mem_stall();
        int guard;
        do_reset();
        lat_lo = 1; lat_hi = 1;
        imem_ready = 1'b1; ins_ready = 1'b1;
        guard = 0;
        while (n_acc < 2 && guard < 20) begin
            step();
            guard++;
        end
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h8) begin
                failures++;
                $display("FAIL stall_hold got req=%b addr=%h exp 1/00000008", s_req, s_addr);
            end
        end
        imem_ready = 1'b1;
        step();
        checks++;
        if (!s_acc || s_addr !== 32'h8) begin
            failures++;
            $display("FAIL stall_release got acc=%b addr=%h exp 1/00000008", s_acc, s_addr);
        end
        step();
        checks++;
        if (s_addr !== 32'hC) begin
            failures++;
            $display("FAIL stall_next got=%h exp=0000000c", s_addr);
        end
    endtask

    task automatic test_redirect_stale();
        int guard, base, inflight;
        do_reset();
        lat_lo = 3; lat_hi = 3;
        imem_ready = 1'b1; ins_ready = 1'b1;
        guard = 0;
        while (exp_fetch != 32'h18 && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (exp_fetch != 32'h18) begin
            failures++;
            $display("FAIL redir_setup got=%h exp=00000018", exp_fetch);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        inflight       = pend.size();
        base           = pop_log.size();
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (!s_acc || s_addr !== 32'h100) begin
            failures++;
            $display("FAIL redir_addr got acc=%b addr=%h exp 1/00000100", s_acc, s_addr);
        end
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (inflight < 2 || pop_log.size() <= base || pop_log[base].pc !== 32'h100) begin
            failures++;
            $display("FAIL redir_first_pc inflight=%0d pops=%0d exp first pc=00000100",
                     inflight, pop_log.size() - base);
        end
    endtask

    task automatic test_redirect_rvalid_pop();
        int t, fa, fv;
        do_reset();
        lat_lo = 1; lat_hi = 1;
        imem_ready = 1'b1; ins_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        step();
        t = s_cyc;
        checks++;
        if (!s_rvalid || s_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_same_cycle got rvalid=%b valid=%b exp 1/1", s_rvalid, s_valid);
        end
        redirect_valid = 1'b0;
        fa = -1; fv = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_acc && fa < 0) fa = s_cyc;
            if (s_valid && fv < 0) fv = s_cyc;
        end
        checks++;
        if (fa != t + 1 || fv != t + 3) begin
            failures++;
            $display("FAIL redir_latency got req=+%0d valid=+%0d exp +1/+3", fa - t, fv - t);
        end
    endtask

    task automatic test_wrap_and_reset();
        int base;
        do_reset();
        lat_lo = 1; lat_hi = 2;
        imem_ready = 1'b1; ins_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        base = pop_log.size();
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (pop_log.size() < base + 3 || pop_log[base].pc !== 32'hFFFF_FFF8
            || pop_log[base+1].pc !== 32'hFFFF_FFFC || pop_log[base+2].pc !== 32'h0
            || pop_log[base+2].ins !== XMASK) begin
            failures++;
            $display("FAIL wrap_seq pops=%0d exp fffffff8,fffffffc,00000000", pop_log.size() - base);
        end
        // Reset lands mid-cycle while the stream is busy.
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RPC || ins_valid !== 1'b0
            || ins !== 32'h0 || ins_pc !== 32'h0) begin
            failures++;
            $display("FAIL midreset_outputs got req=%b addr=%h v=%b ins=%h pc=%h exp 0/%h/0/0/0",
                     imem_req, imem_addr, ins_valid, ins, ins_pc, RPC);
        end
        do_reset();
        imem_ready = 1'b1; ins_ready = 1'b1;
        base = pop_log.size();
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (pop_log.size() <= base || pop_log[base].pc !== RPC) begin
            failures++;
            $display("FAIL midreset_restart pops=%0d exp first pc=%h", pop_log.size() - base, RPC);
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 1500; i++) begin
            imem_ready     = ($urandom_range(3, 0) != 0);
            ins_ready      = ($urandom_range(2, 0) != 0);
            redirect_valid = ($urandom_range(29, 0) == 0);
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        checks++;
        if (n_pop < 100) begin
            failures++;
            $display("FAIL random_progress got=%0d exp>=100", n_pop);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_mem_stall();
        test_redirect_stale();
        test_redirect_rvalid_pop();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
